// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
//
// Store-and-forward AXI-Stream packet FIFO. Ingress beats are buffered, and a
// packet is offered on the master side only after its tlast beat has been
// stored. Downstream logic therefore never sees a partial packet or bubbles
// caused by the source.
//
// Compile-time option:
//   AXIS_PKT_FIFO_DROP_EN  When defined, ingress is never back-pressured.
//                          A packet that does not fit is discarded and
//                          counted in drop_count. When undefined, ingress
//                          stalls while storage is full and drop_count is 0.
//
// Handshake: a beat transfers on a rising edge where tvalid && tready are
// both high. A master holds tdata/tlast stable while tvalid && !tready. The
// egress side of this block presents tvalid without looking at tready.
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   ingress data
//   s_axis_tlast   ingress end of packet
//   s_axis_tvalid  ingress valid
//   s_axis_tready  ingress ready
//   m_axis_tdata   egress data (combinational read of the head entry)
//   m_axis_tlast   egress end of packet
//   m_axis_tvalid  egress valid (a complete packet is stored)
//   m_axis_tready  egress ready
//   pkt_count      complete packets currently stored
//   drop_count     discarded packets, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module axis_pkt_fifo #(
    parameter  int TDATA_WIDTH = 32,
    parameter  int DEPTH       = 16,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [AW:0]            pkt_count,
    output logic [15:0]            drop_count
);

    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    // Each entry holds {tlast, tdata}. Contents are not reset.
    logic [TDATA_WIDTH:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [AW:0] wr_ptr_q,     wr_ptr_d;
    logic [AW:0] commit_ptr_q, commit_ptr_d;
    logic [AW:0] rd_ptr_q,     rd_ptr_d;
    logic [AW:0] pkt_count_q,  pkt_count_d;

    // Low during reset. It rises on the first edge after release, so
    // ingress opens one cycle after reset is released.
    logic ready_q;

    logic [AW:0]            used;
    logic                   full;
    logic                   s_fire;
    logic                   m_fire;
    logic                   wr_en;
    logic                   pkt_in;
    logic                   pkt_out;
    logic [TDATA_WIDTH-1:0] rd_data;
    logic                   rd_last;

`ifdef AXIS_PKT_FIFO_DROP_EN
    logic        dropping_q, dropping_d;
    logic [15:0] drop_count_q, drop_count_d;
`endif

    assign used = wr_ptr_q - rd_ptr_q;
    assign full = (used == FULL_LVL);

    // Only committed beats, up to commit_ptr, are visible to the egress side.
    assign m_axis_tvalid       = (rd_ptr_q != commit_ptr_q);
    assign {rd_last, rd_data}  = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_tdata        = rd_data;
    assign m_axis_tlast        = m_axis_tvalid && rd_last;
    assign m_fire              = m_axis_tvalid && m_axis_tready;
    assign pkt_out             = m_fire && rd_last;

`ifdef AXIS_PKT_FIFO_DROP_EN
    assign s_axis_tready = ready_q;
    assign drop_count    = drop_count_q;
`else
    // full comes from registered pointers. A read frees space only from
    // the following cycle, so there is no same-cycle pass-through.
    assign s_axis_tready = ready_q && !full;
    assign drop_count    = 16'h0000;
`endif
    assign s_fire    = s_axis_tvalid && s_axis_tready;
    assign pkt_count = pkt_count_q;

    always_comb begin
        wr_en        = 1'b0;
        pkt_in       = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
`ifdef AXIS_PKT_FIFO_DROP_EN
        dropping_d   = dropping_q;
        drop_count_d = drop_count_q;
        if (s_fire) begin
            if (full || dropping_q) begin
                if (s_axis_tlast) begin
                    // Rewind past the partial packet. Committed data is untouched.
                    wr_ptr_d   = commit_ptr_q;
                    dropping_d = 1'b0;
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                end else begin
                    dropping_d = 1'b1;
                end
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (s_axis_tlast) begin
                    commit_ptr_d = wr_ptr_q + PTR_ONE;
                    pkt_in       = 1'b1;
                end
            end
        end
`else
        if (s_fire) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis_tlast) begin
                commit_ptr_d = wr_ptr_q + PTR_ONE;
                pkt_in       = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        rd_ptr_d    = m_fire ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        pkt_count_d = pkt_count_q;
        case ({pkt_in, pkt_out})
            2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
            2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
            ready_q      <= 1'b1;
        end
    end

`ifdef AXIS_PKT_FIFO_DROP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropping_q   <= 1'b0;
            drop_count_q <= 16'h0000;
        end else begin
            dropping_q   <= dropping_d;
            drop_count_q <= drop_count_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
module tb_axis_pkt_fifo;

    localparam int W       = 32;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [AW:0]   pkt_count;
    logic [15:0]   drop_count;

    int tests_run = 0;
    int fails     = 0;

    axis_pkt_fifo #(.TDATA_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sink driver ----------------
    // 0 = always ready, 1 = stalled, 2 = random
    int sink_mode = 1;
    always @(posedge clk) begin
        #1;
        case (sink_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'($urandom_range(1, 0));
        endcase
    end

    // ---------------- reference model / scoreboard ----------------
    // exp_q holds every stored beat in arrival order; the first `committed`
    // entries belong to complete packets and are the only ones visible.
    logic [W:0] exp_q[$];
    int  committed    = 0;
    int  m_pkts       = 0;
    int  m_drops      = 0;
    int  egress_beats = 0;
    bit  armed        = 0;
    bit  m_dropping   = 0;

    always @(negedge clk) begin : monitor
        int         used0;
        bit         exp_rdy;
        bit         exp_vld;
        bit         s_fire;
        bit         m_fire;
        logic [W:0] b;
        if (!rst_n) begin
            exp_q.delete();
            committed  = 0;
            m_pkts     = 0;
            m_drops    = 0;
            armed      = 0;
            m_dropping = 0;
        end else begin
            used0   = exp_q.size();
            exp_vld = (committed > 0);
`ifdef AXIS_PKT_FIFO_DROP_EN
            exp_rdy = armed;
`else
            exp_rdy = armed && (used0 < DEPTH);
`endif
            tests_run += 4;
            if (s_axis_tready !== exp_rdy) begin
                fails++;
                $display("FAIL mon_s_tready @%0t: got %b expected %b", $time, s_axis_tready, exp_rdy);
            end
            if (m_axis_tvalid !== exp_vld) begin
                fails++;
                $display("FAIL mon_m_tvalid @%0t: got %b expected %b", $time, m_axis_tvalid, exp_vld);
            end
            if (pkt_count !== (AW+1)'(m_pkts)) begin
                fails++;
                $display("FAIL mon_pkt_count @%0t: got %0d expected %0d", $time, pkt_count, m_pkts);
            end
            if (drop_count !== 16'(m_drops)) begin
                fails++;
                $display("FAIL mon_drop_count @%0t: got %0d expected %0d", $time, drop_count, m_drops);
            end
            tests_run++;
            if (exp_vld) begin
                if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin
                    fails++;
                    $display("FAIL mon_egress_beat @%0t: got last=%b data=%0h expected last=%b data=%0h",
                             $time, m_axis_tlast, m_axis_tdata, exp_q[0][W], exp_q[0][W-1:0]);
                end
            end else if (m_axis_tlast !== 1'b0) begin
                fails++;
                $display("FAIL mon_idle_tlast @%0t: got %b expected 0", $time, m_axis_tlast);
            end

            m_fire = exp_vld && (m_axis_tready === 1'b1);
            s_fire = (s_axis_tvalid === 1'b1) && exp_rdy;
            if (m_fire) begin
                b = exp_q.pop_front();
                committed--;
                if (b[W]) m_pkts--;
                egress_beats++;
            end
            if (s_fire) begin
`ifdef AXIS_PKT_FIFO_DROP_EN
                if (m_dropping || used0 == DEPTH) begin
                    if (s_axis_tlast) begin
                        while (exp_q.size() > committed) void'(exp_q.pop_back());
                        m_dropping = 0;
                        if (m_drops < 65535) m_drops++;
                    end else begin
                        m_dropping = 1;
                    end
                end else
`endif
                begin
                    exp_q.push_back({s_axis_tlast, s_axis_tdata});
                    if (s_axis_tlast) begin
                        committed = exp_q.size();
                        m_pkts++;
                    end
                end
            end
            armed = 1;
        end
    end

    // ---------------- source driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int waited = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && waited < TIMEOUT) begin
            waited++;
            @(negedge clk);
        end
        if (s_axis_tready !== 1'b1) begin
            tests_run++;
            fails++;
            $display("FAIL ingress_timeout: tready stayed %b, required 1 within %0d cycles", s_axis_tready, TIMEOUT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input logic [W-1:0] base, input int max_gap);
        int gap;
        @(posedge clk);
        #1;
        for (int i = 0; i < len; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (gap > 0) begin
                s_axis_tvalid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(base + W'(i), (i == len - 1));
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < TIMEOUT) begin
            @(posedge clk);
            #2;
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d beats still expected after %0d cycles, required 0", exp_q.size(), TIMEOUT);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        sink_mode = 1;
        repeat (3) @(posedge clk);
        #2;
        tests_run += 5;
        if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL rst_s_tready: got %b expected 0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_m_tvalid: got %b expected 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0)  begin fails++; $display("FAIL rst_m_tlast: got %b expected 0", m_axis_tlast); end
        if (pkt_count !== '0)       begin fails++; $display("FAIL rst_pkt_count: got %0d expected 0", pkt_count); end
        if (drop_count !== '0)      begin fails++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        tests_run++;
        if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL rst_release_tready: got %b expected 0", s_axis_tready); end
        @(posedge clk);
        #2;
        tests_run++;
        if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL rst_first_edge_tready: got %b expected 1", s_axis_tready); end
    endtask

    task automatic test_single();
        int eb0;
        sink_mode = 0;
        eb0 = egress_beats;
        @(posedge clk);
        #1;
        send_beat(32'h1, 1'b0);
        send_beat(32'h2, 1'b0);
        send_beat(32'h3, 1'b0);
        s_axis_tvalid = 1'b0;
        #1;
        tests_run += 2;
        if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b expected 0", m_axis_tvalid); end
        if (pkt_count !== '0)       begin fails++; $display("FAIL single_early_count: got %0d expected 0", pkt_count); end
        send_beat(32'h4, 1'b1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #1;
        tests_run += 4;
        if (m_axis_tvalid !== 1'b1)   begin fails++; $display("FAIL single_latency_valid: got %b expected 1", m_axis_tvalid); end
        if (m_axis_tdata !== 32'h1)   begin fails++; $display("FAIL single_first_data: got %0h expected 1", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0)    begin fails++; $display("FAIL single_first_last: got %b expected 0", m_axis_tlast); end
        if (pkt_count !== (AW+1)'(1)) begin fails++; $display("FAIL single_count_one: got %0d expected 1", pkt_count); end
        wait_drain();
        tests_run += 2;
        if (pkt_count !== '0)          begin fails++; $display("FAIL single_count_zero: got %0d expected 0", pkt_count); end
        if (egress_beats - eb0 !== 4)  begin fails++; $display("FAIL single_beats: got %0d expected 4", egress_beats - eb0); end
    endtask

    task automatic test_gaps();
        int gaps = 0;
        sink_mode = 0;
        send_pkt(8, 32'h300, 9);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (m_axis_tvalid !== 1'b1) gaps++;
            @(posedge clk);
            #2;
        end
        tests_run += 2;
        if (gaps !== 0)             begin fails++; $display("FAIL gaps_egress_bubbles: got %0d expected 0", gaps); end
        if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL gaps_after_pkt_valid: got %b expected 0", m_axis_tvalid); end
    endtask

`ifndef AXIS_PKT_FIFO_DROP_EN
    task automatic test_full();
        int eb0;
        @(negedge clk) sink_mode = 1;
        eb0 = egress_beats;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_beat(32'h200 + W'(i), 1'b1);
        s_axis_tvalid = 1'b0;
        #1;
        tests_run += 3;
        if (s_axis_tready !== 1'b0)    begin fails++; $display("FAIL full_tready: got %b expected 0", s_axis_tready); end
        if (pkt_count !== (AW+1)'(16)) begin fails++; $display("FAIL full_pkt_count: got %0d expected 16", pkt_count); end
        if (m_axis_tvalid !== 1'b1)    begin fails++; $display("FAIL full_m_tvalid: got %b expected 1", m_axis_tvalid); end
        s_axis_tdata  = 32'h2FF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        tests_run += 2;
        if (s_axis_tready !== 1'b0)    begin fails++; $display("FAIL full_hold_tready: got %b expected 0", s_axis_tready); end
        if (pkt_count !== (AW+1)'(16)) begin fails++; $display("FAIL full_hold_count: got %0d expected 16", pkt_count); end
        @(negedge clk) sink_mode = 0;
        @(posedge clk);
        #2;
        tests_run++;
        if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL full_no_passthrough: got %b expected 0", s_axis_tready); end
        @(posedge clk);
        #2;
        tests_run++;
        if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL full_tready_return: got %b expected 1", s_axis_tready); end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        wait_drain();
        tests_run += 2;
        if (egress_beats - eb0 !== 17) begin fails++; $display("FAIL full_beats: got %0d expected 17", egress_beats - eb0); end
        if (pkt_count !== '0)          begin fails++; $display("FAIL full_drained_count: got %0d expected 0", pkt_count); end
    endtask
`endif

    task automatic test_stall();
        int eb0;
        @(negedge clk) sink_mode = 1;
        eb0 = egress_beats;
        send_pkt(6, 32'h100, 0);
        @(negedge clk) sink_mode = 0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        @(negedge clk) sink_mode = 1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) begin
            tests_run += 3;
            if (m_axis_tvalid !== 1'b1)  begin fails++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, m_axis_tvalid); end
            if (m_axis_tdata !== 32'h102) begin fails++; $display("FAIL stall_data[%0d]: got %0h expected 102", i, m_axis_tdata); end
            if (m_axis_tlast !== 1'b0)   begin fails++; $display("FAIL stall_last[%0d]: got %b expected 0", i, m_axis_tlast); end
            @(posedge clk);
            #2;
        end
        sink_mode = 0;
        wait_drain();
        tests_run++;
        if (egress_beats - eb0 !== 6) begin fails++; $display("FAIL stall_beats: got %0d expected 6", egress_beats - eb0); end
    endtask

`ifdef AXIS_PKT_FIFO_DROP_EN
    task automatic test_drop();
        int eb0;
        @(negedge clk) sink_mode = 1;
        eb0 = egress_beats;
        send_pkt(10, 32'h400, 0);
        send_pkt(10, 32'h500, 0);
        #1;
        tests_run += 2;
        if (drop_count !== 16'd1)     begin fails++; $display("FAIL drop_count_one: got %0d expected 1", drop_count); end
        if (pkt_count !== (AW+1)'(1)) begin fails++; $display("FAIL drop_pkt_count: got %0d expected 1", pkt_count); end
        send_pkt(4, 32'h600, 0);
        #1;
        tests_run += 2;
        if (pkt_count !== (AW+1)'(2)) begin fails++; $display("FAIL drop_next_committed: got %0d expected 2", pkt_count); end
        if (drop_count !== 16'd1)     begin fails++; $display("FAIL drop_count_stable: got %0d expected 1", drop_count); end
        sink_mode = 0;
        wait_drain();
        tests_run++;
        if (egress_beats - eb0 !== 14) begin fails++; $display("FAIL drop_beats: got %0d expected 14", egress_beats - eb0); end
    endtask
`endif

    task automatic test_reset_mid();
        int eb0;
        @(negedge clk) sink_mode = 1;
        send_pkt(2, 32'h50, 0);
        @(posedge clk);
        #1;
        send_beat(32'h60, 1'b0);
        send_beat(32'h61, 1'b0);
        s_axis_tvalid = 1'b0;
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL rmid_pre_valid: got %b expected 1", m_axis_tvalid); end
        rst_n = 1'b0;
        #1;
        tests_run += 5;
        if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b expected 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0)  begin fails++; $display("FAIL rmid_last: got %b expected 0", m_axis_tlast); end
        if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL rmid_tready: got %b expected 0", s_axis_tready); end
        if (pkt_count !== '0)       begin fails++; $display("FAIL rmid_pkt_count: got %0d expected 0", pkt_count); end
        if (drop_count !== '0)      begin fails++; $display("FAIL rmid_drop_count: got %0d expected 0", drop_count); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sink_mode = 0;
        @(posedge clk);
        #2;
        eb0 = egress_beats;
        send_pkt(3, 32'hA, 0);
        wait_drain();
        tests_run++;
        if (egress_beats - eb0 !== 3) begin fails++; $display("FAIL rmid_new_pkt_beats: got %0d expected 3", egress_beats - eb0); end
    endtask

    task automatic test_random();
        int eb0;
        int total = 0;
        int len;
        sink_mode = 2;
        eb0 = egress_beats;
        for (int p = 0; p < 12; p++) begin
            len = int'($urandom_range(8, 1));
            total += len;
            send_pkt(len, 32'h1000 * W'(p + 1) + W'($urandom_range(255, 0)) * 32'h10, 3);
        end
        sink_mode = 0;
        wait_drain();
`ifndef AXIS_PKT_FIFO_DROP_EN
        tests_run++;
        if (egress_beats - eb0 !== total) begin fails++; $display("FAIL random_beats: got %0d expected %0d", egress_beats - eb0, total); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
`ifdef AXIS_PKT_FIFO_DROP_EN
        test_drop();
`endif
        test_single();
        test_gaps();
`ifndef AXIS_PKT_FIFO_DROP_EN
        test_full();
`endif
        test_stall();
        test_reset_mid();
        test_random();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
